// File: rtl/imem_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words and writes them to instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before releasing the core.
module imem_loader #(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [15:0] MAX_N = 16'(MEM_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_DONE, S_ERR, S_CSUM} state_t;
    logic [7:0]  xor_q;
`else
    typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;
`endif

    state_t            state_q;
    logic              byte_ready_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic              core_hold_q;
    logic              done_q;
    logic              error_q;
    logic [CNT_W-1:0]  words_q;
    logic [1:0]        idx_q;
    logic [15:0]       count_q;
    logic [31:0]       word_q;

    logic              xfer_s;
    logic [15:0]       count_d;
    logic [CNT_W-1:0]  words_d;
    logic [31:0]       word_d;

    assign xfer_s  = byte_valid & byte_ready_q;
    assign count_d = {byte_data, count_q[7:0]};
    assign words_d = words_q + CNT_W'(1);

    // Word being assembled with the current stream byte dropped into its lane.
    always_comb begin
        word_d = word_q;
        case (idx_q)
            2'd0:    word_d[7:0]   = byte_data;
            2'd1:    word_d[15:8]  = byte_data;
            2'd2:    word_d[23:16] = byte_data;
            2'd3:    word_d[31:24] = byte_data;
            default: word_d        = word_q;
        endcase
    end

    // Loader FSM; every output is a register updated on the transition into its state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 32'd0;
            core_hold_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            words_q      <= '0;
            idx_q        <= 2'd0;
            count_q      <= 16'd0;
            word_q       <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q        <= 8'd0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q      <= S_HDR0;
                        byte_ready_q <= 1'b1;
                        core_hold_q  <= 1'b1;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        words_q      <= '0;
                        wr_addr_q    <= '0;
                        idx_q        <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_q        <= 8'd0;
`endif
                    end
                end
                S_HDR0: begin
                    if (xfer_s) begin
                        count_q[7:0] <= byte_data;
                        state_q      <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (xfer_s) begin
                        count_q[15:8] <= byte_data;
                        // Rejecting oversize counts here is what keeps wr_addr from wrapping mid-load.
                        if (count_d == 16'd0 || count_d > MAX_N) begin
                            state_q      <= S_ERR;
                            byte_ready_q <= 1'b0;
                            error_q      <= 1'b1;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer_s) begin
                        word_q <= word_d;
                        idx_q  <= idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_q  <= xor_q ^ byte_data;
`endif
                        if (idx_q == 2'd3) begin
                            state_q      <= S_WRITE;
                            byte_ready_q <= 1'b0;
                            wr_en_q      <= 1'b1;
                            wr_data_q    <= word_d;
                        end
                    end
                end
                S_WRITE: begin
                    wr_addr_q <= wr_addr_q + ADDR_W'(1);
                    words_q   <= words_d;
                    if (16'(words_d) == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_q      <= S_CSUM;
                        byte_ready_q <= 1'b1;
`else
                        state_q      <= S_DONE;
                        done_q       <= 1'b1;
                        core_hold_q  <= 1'b0;
`endif
                    end else begin
                        state_q      <= S_DATA;
                        byte_ready_q <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (xfer_s) begin
                        byte_ready_q <= 1'b0;
                        if (byte_data == xor_q) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            core_hold_q <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q      <= S_IDLE;
                    byte_ready_q <= 1'b0;
                    core_hold_q  <= 1'b1;
                end
            endcase
        end
    end

    assign byte_ready   = byte_ready_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign core_hold    = core_hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; one task per scenario, inline checks, writes logged from wr_en pulses.
module tb_imem_loader;

    localparam int MW = 1024;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          core_hold;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    int errs = 0;
    int checks = 0;
    int timeouts = 0;
    logic [AW-1:0] log_addr[$];
    logic [31:0]   log_data[$];

    imem_loader #(.MEM_WORDS(MW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(rst_n), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .core_hold(core_hold), .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && t < 20 && timeouts < 4) begin
            @(negedge clk);
            t++;
        end
        if (byte_ready !== 1'b1) begin
            timeouts++;
            checks++; errs++;
            $display("FAIL send_byte_timeout: byte_ready=%b required 1", byte_ready);
        end else begin
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        checks++; if (byte_ready !== 1'b0) begin errs++; $display("FAIL rst_byte_ready: got %b exp 0", byte_ready); end
        checks++; if (wr_en !== 1'b0) begin errs++; $display("FAIL rst_wr_en: got %b exp 0", wr_en); end
        checks++; if (wr_addr !== 10'd0) begin errs++; $display("FAIL rst_wr_addr: got %0d exp 0", wr_addr); end
        checks++; if (wr_data !== 32'd0) begin errs++; $display("FAIL rst_wr_data: got %h exp 0", wr_data); end
        checks++; if (core_hold !== 1'b1) begin errs++; $display("FAIL rst_core_hold: got %b exp 1", core_hold); end
        checks++; if (done !== 1'b0 || error !== 1'b0) begin errs++; $display("FAIL rst_done_err: got %b%b exp 00", done, error); end
        checks++; if (words_loaded !== 11'd0) begin errs++; $display("FAIL rst_words: got %0d exp 0", words_loaded); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (byte_ready !== 1'b0 || core_hold !== 1'b1) begin errs++; $display("FAIL idle_hold: ready=%b hold=%b exp 0/1", byte_ready, core_hold); end
    endtask

    task automatic test_basic();
        log_addr.delete(); log_data.delete();
        pulse_start();
        checks++; if (byte_ready !== 1'b1 || core_hold !== 1'b1) begin errs++; $display("FAIL basic_hdr0: ready=%b hold=%b exp 1/1", byte_ready, core_hold); end
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'h00A00513, 0);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 10'd0 || wr_data !== 32'h00A00513) begin errs++; $display("FAIL basic_w0: en=%b addr=%0d data=%h exp 1/0/00a00513", wr_en, wr_addr, wr_data); end
        send_word(32'h00500593, 0);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 10'd1 || wr_data !== 32'h00500593) begin errs++; $display("FAIL basic_w1: en=%b addr=%0d data=%h exp 1/1/00500593", wr_en, wr_addr, wr_data); end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h70, 0);
`else
        @(negedge clk);
`endif
        checks++; if (done !== 1'b1 || core_hold !== 1'b0 || error !== 1'b0) begin errs++; $display("FAIL basic_done: done=%b hold=%b err=%b exp 1/0/0", done, core_hold, error); end
        checks++; if (words_loaded !== 11'd2) begin errs++; $display("FAIL basic_words: got %0d exp 2", words_loaded); end
        @(negedge clk);
        checks++;
        if (log_addr.size() != 2) begin errs++; $display("FAIL basic_log_size: got %0d exp 2", log_addr.size()); end
        else if (log_addr[0] !== 10'd0 || log_data[0] !== 32'h00A00513 || log_addr[1] !== 10'd1 || log_data[1] !== 32'h00500593) begin
            errs++; $display("FAIL basic_log: %0d:%h %0d:%h exp 0:00a00513 1:00500593", log_addr[0], log_data[0], log_addr[1], log_data[1]);
        end
    endtask

    task automatic test_restart();
        log_addr.delete(); log_data.delete();
        pulse_start();
        checks++; if (core_hold !== 1'b1 || done !== 1'b0) begin errs++; $display("FAIL restart_edge: hold=%b done=%b exp 1/0", core_hold, done); end
        checks++; if (words_loaded !== 11'd0 || byte_ready !== 1'b1) begin errs++; $display("FAIL restart_clear: words=%0d ready=%b exp 0/1", words_loaded, byte_ready); end
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'h44332211, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h44, 0);
`else
        @(negedge clk);
`endif
        checks++; if (done !== 1'b1 || words_loaded !== 11'd1) begin errs++; $display("FAIL restart_done: done=%b words=%0d exp 1/1", done, words_loaded); end
        @(negedge clk);
        checks++;
        if (log_addr.size() != 1) begin errs++; $display("FAIL restart_log_size: got %0d exp 1", log_addr.size()); end
        else if (log_addr[0] !== 10'd0 || log_data[0] !== 32'h44332211) begin errs++; $display("FAIL restart_log: %0d:%h exp 0:44332211", log_addr[0], log_data[0]); end
    endtask

    task automatic test_bad_header(input logic [7:0] lo, input logic [7:0] hi);
        log_addr.delete(); log_data.delete();
        pulse_start();
        checks++; if (error !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL hdr_%h%h_clear: err=%b done=%b exp 0/0", hi, lo, error, done); end
        send_byte(lo, 0);
        send_byte(hi, 0);
        checks++; if (error !== 1'b1 || core_hold !== 1'b1 || byte_ready !== 1'b0) begin errs++; $display("FAIL hdr_%h%h_err: err=%b hold=%b ready=%b exp 1/1/0", hi, lo, error, core_hold, byte_ready); end
        repeat (3) @(negedge clk);
        checks++; if (log_addr.size() != 0 || error !== 1'b1 || done !== 1'b0) begin errs++; $display("FAIL hdr_%h%h_nowrite: writes=%0d err=%b done=%b exp 0/1/0", hi, lo, log_addr.size(), error, done); end
    endtask

    task automatic test_gaps();
        logic [7:0] s[10];
        int g[10];
        s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
        g = '{1, 0, 3, 2, 0, 1, 4, 0, 2, 1};
        log_addr.delete(); log_data.delete();
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(s[i], g[i]);
        pulse_start();
        checks++; if (byte_ready !== 1'b1 || words_loaded !== 11'd1 || core_hold !== 1'b1) begin errs++; $display("FAIL gaps_start_ignored: ready=%b words=%0d hold=%b exp 1/1/1", byte_ready, words_loaded, core_hold); end
        for (int i = 8; i < 10; i++) send_byte(s[i], g[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h70, 2);
`else
        @(negedge clk);
`endif
        checks++; if (done !== 1'b1 || words_loaded !== 11'd2) begin errs++; $display("FAIL gaps_done: done=%b words=%0d exp 1/2", done, words_loaded); end
        @(negedge clk);
        checks++;
        if (log_addr.size() != 2) begin errs++; $display("FAIL gaps_log_size: got %0d exp 2", log_addr.size()); end
        else if (log_addr[0] !== 10'd0 || log_data[0] !== 32'h00A00513 || log_addr[1] !== 10'd1 || log_data[1] !== 32'h00500593) begin
            errs++; $display("FAIL gaps_log: %0d:%h %0d:%h exp 0:00a00513 1:00500593", log_addr[0], log_data[0], log_addr[1], log_data[1]);
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum_bad();
        log_addr.delete(); log_data.delete();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'h00A00513, 0);
        send_word(32'h00500593, 0);
        send_byte(8'h71, 0);
        checks++; if (error !== 1'b1 || done !== 1'b0 || core_hold !== 1'b1) begin errs++; $display("FAIL csum_bad: err=%b done=%b hold=%b exp 1/0/1", error, done, core_hold); end
        @(negedge clk);
        checks++; if (log_addr.size() != 2) begin errs++; $display("FAIL csum_bad_writes: got %0d exp 2", log_addr.size()); end
    endtask
`endif

    task automatic test_full();
        logic [31:0] w;
        logic [7:0]  x;
        int bad;
        x = 8'd0;
        bad = 0;
        log_addr.delete(); log_data.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        for (int i = 0; i < MW; i++) begin
            w = 32'hA5000000 ^ (i * 32'h00010003);
            x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            send_word(w, 0);
        end
        checks++; if (wr_en !== 1'b1 || wr_addr !== 10'd1023 || wr_data !== w) begin errs++; $display("FAIL full_last: en=%b addr=%0d data=%h exp 1/1023/%h", wr_en, wr_addr, wr_data, w); end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(x, 0);
`else
        @(negedge clk);
`endif
        checks++; if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 11'd1024) begin errs++; $display("FAIL full_done: done=%b err=%b words=%0d exp 1/0/1024", done, error, words_loaded); end
        @(negedge clk);
        checks++;
        if (log_addr.size() != MW) begin errs++; $display("FAIL full_log_size: got %0d exp %0d", log_addr.size(), MW); end
        else begin
            for (int i = 0; i < MW; i++) begin
                w = 32'hA5000000 ^ (i * 32'h00010003);
                if (log_addr[i] !== AW'(i) || log_data[i] !== w) bad++;
            end
            if (bad != 0) begin errs++; $display("FAIL full_log: %0d wrong words exp 0", bad); end
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'h11111111, 0);
        send_byte(8'h22, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (byte_ready !== 1'b0 || wr_en !== 1'b0 || wr_addr !== 10'd0 || wr_data !== 32'd0) begin errs++; $display("FAIL midrst_wr: ready=%b en=%b addr=%0d data=%h exp 0/0/0/0", byte_ready, wr_en, wr_addr, wr_data); end
        checks++; if (core_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0 || words_loaded !== 11'd0) begin errs++; $display("FAIL midrst_stat: hold=%b done=%b err=%b words=%0d exp 1/0/0/0", core_hold, done, error, words_loaded); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (byte_ready !== 1'b0 || core_hold !== 1'b1) begin errs++; $display("FAIL midrst_idle: ready=%b hold=%b exp 0/1", byte_ready, core_hold); end
    endtask

    initial begin
        rst_n      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        test_reset();
        test_basic();
        test_restart();
        test_bad_header(8'h00, 8'h00);
        test_bad_header(8'h01, 8'h04);
        test_gaps();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum_bad();
`endif
        test_full();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that instruction fetch reads from.
- Accepts a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit instruction words.
- Writes the words to consecutive word addresses starting at 0.
- Holds the core in reset until the load completes successfully.

Parameters:
- MEM_WORDS, 1024, instruction memory depth in 32-bit words; maximum legal word count.
- ADDR_W, 10, word-address width; must satisfy 2^ADDR_W >= MEM_WORDS.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load. Honoured in IDLE, DONE and ERR only.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts byte_data this cycle.
- wr_en  output  1  instruction-memory write strobe, one cycle per word.
- wr_addr  output  ADDR_W  word address (byte address = wr_addr*4).
- wr_data  output  32  instruction word.
- core_hold  output  1  high means the processor reset is held asserted.
- done  output  1  load completed successfully.
- error  output  1  load aborted.
- words_loaded  output  ADDR_W+1  count of words written in the current or last load.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state IDLE; byte_ready=0, wr_en=0, wr_addr=0, wr_data=0;
  - core_hold=1, done=0, error=0, words_loaded=0;
  - internal byte index=0, word count=0.
- A byte transfer happens on a rising edge where byte_valid && byte_ready. byte_data is sampled on that edge only.
- byte_ready is a registered output: 1 in HDR0, HDR1, DATA (and CSUM when CHECKSUM_EN is defined); 0 in every other state.
- Stream format: count_lo, count_hi (16-bit little-endian word count N), then 4*N data bytes, least-significant byte of each word first.
- States and transitions:
  - IDLE: start -> HDR0; clears done, error, words_loaded and wr_addr; core_hold=1.
  - HDR0: on transfer, latch count[7:0] -> HDR1.
  - HDR1: on transfer, latch count[15:8]. If N==0 or N>MEM_WORDS -> ERR; else -> DATA.
  - DATA: on each transfer, place the byte at bits [8*idx+7:8*idx] of the word being assembled; idx increments modulo 4. On the 4th byte -> WRITE.
  - WRITE (exactly one cycle): wr_en=1, wr_data=assembled word, wr_addr=current address. On the next edge, wr_addr increments and words_loaded increments. If words_loaded reaches N -> DONE (or CSUM under CHECKSUM_EN); else -> DATA.
  - DONE: done=1, core_hold=0. start -> HDR0 with core_hold re-asserted and done cleared in that same transition edge.
  - ERR: error=1, core_hold=1. start -> HDR0 with error cleared.
- Latency:
  - wr_en rises the cycle after the 4th byte of a word is accepted.
  - Maximum throughput is 4 bytes per 5 cycles.
  - done rises the cycle after the last WRITE.
- start while in HDR0/HDR1/DATA/WRITE is ignored.
- byte_valid without byte_ready: no effect; the byte stays pending at the source.
- wr_addr never wraps within a load, because N<=MEM_WORDS is enforced by HDR1.
- Asynchronous reset mid-load returns to IDLE with core_hold=1. Words already written are left in memory and not reported.
- wr_data and wr_addr hold their last values when wr_en=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - after the last WRITE, enter CSUM and accept one extra byte;
  - compare it with the running XOR of all 4*N data bytes (header excluded);
  - match -> DONE; mismatch -> ERR. Words already written stay written, but core_hold remains 1.
- Undefined: no CSUM state; last WRITE -> DONE directly; no XOR register is synthesised.

Test Plan:
- Reset=0 mid-stream, then release.
  - Required: all outputs at reset values immediately (asynchronous).
  - Required: core_hold=1, byte_ready=0 until start.
- start, then stream 02 00 13 05 A0 00 93 05 50 00 (plus 70 when checksum is enabled).
  - Required: wr_en pulses with addr 0 data 0x00A00513, then addr 1 data 0x00500593.
  - Required: done=1, core_hold=0, words_loaded=2.
- Header 00 00.
  - Required: ERR the cycle after the second header byte; error=1, core_hold=1, no wr_en pulse.
- Header with N=MEM_WORDS+1 (0x0401 for default).
  - Required: ERR, no writes.
- Header with N=MEM_WORDS.
  - Required: final write at wr_addr=MEM_WORDS-1, then done.
- Source toggles byte_valid randomly (gaps); start pulsed mid-DATA.
  - Required: same words written as a gap-free stream; start has no effect.
- Checksum enabled, trailing byte 71 instead of 70.
  - Required: error=1, done=0, core_hold=1, both words still written.
- Restart from DONE with start.
  - Required: core_hold=1 and done=0 on the next edge.
  - Required: a new load overwrites from address 0.
